// File: rtl/sync_debounce.sv
// sync_debounce: multi-channel pin conditioner. Each channel passes through a
// flop-chain synchroniser followed by a consecutive-cycle debounce filter, and
// produces raw synced level, debounced level and one-cycle rise/fall pulses.
`timescale 1ns/1ps

module sync_debounce #(
   parameter int   WIDTH           = 4,
   parameter int   STAGES          = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_async_i,
   output logic [WIDTH-1:0] out_sync_o,
   output logic [WIDTH-1:0] out_stable_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Count value on which the pending level is accepted as stable.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
   logic [CW-1:0] cnt [WIDTH];

   assign out_sync_o = sync_q[STAGES-1];

   // Synchroniser chain: stage 0 samples the pins, later stages are pure shifts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= {WIDTH{RESET_VAL}};
         end
      end else begin
         sync_q[0] <= in_async_i;
         for (int s = 1; s < STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Per-channel debounce: count consecutive cycles of disagreement, accept the
   // synced level on the last one and fire the matching edge pulse alongside it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         out_stable_o <= {WIDTH{RESET_VAL}};
         rise_o       <= '0;
         fall_o       <= '0;
      end else begin
         rise_o <= '0;
         fall_o <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (out_sync_o[i] == out_stable_o[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               out_stable_o[i] <= out_sync_o[i];
               cnt[i]          <= '0;
               rise_o[i]       <= out_sync_o[i];
               fall_o[i]       <= ~out_sync_o[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce: a default build (STAGES=2, 4-cycle
// debounce) and a 1-cycle debounce build. Expected edge events are queued
// when stimulus is driven and matched against DUT pulses as they appear.
`timescale 1ns/1ps

module tb_sync_debounce;

   localparam int STG = 2;
   localparam int DC0 = 4;
   localparam int DC1 = 1;

   typedef struct {
      int ch;
      int at;
      bit rise;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in0 = 4'h0;
   logic [3:0] in1 = 4'h0;
   logic [3:0] sync0, stable0, rise0, fall0;
   logic [3:0] sync1, stable1, rise1, fall1;

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   ev_t  q0[$];
   ev_t  q1[$];

   sync_debounce #(.WIDTH(4), .STAGES(STG), .DEBOUNCE_CYCLES(DC0), .RESET_VAL(1'b0)) dut0 (
      .clk_i(clk), .rst_i(rst), .in_async_i(in0),
      .out_sync_o(sync0), .out_stable_o(stable0), .rise_o(rise0), .fall_o(fall0)
   );

   sync_debounce #(.WIDTH(4), .STAGES(STG), .DEBOUNCE_CYCLES(DC1), .RESET_VAL(1'b0)) dut1 (
      .clk_i(clk), .rst_i(rst), .in_async_i(in1),
      .out_sync_o(sync1), .out_stable_o(stable1), .rise_o(rise1), .fall_o(fall1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int d, input int ch, input int at, input bit rise);
      ev_t e;
      e.ch = ch; e.at = at; e.rise = rise;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(input int d, input logic [3:0] r, input logic [3:0] f, input logic [3:0] st);
      ev_t e;
      int  n;
      for (int c = 0; c < 4; c++) begin
         if (r[c] || f[c]) begin
            n = (d == 0) ? q0.size() : q1.size();
            if (n == 0) begin
               chk($sformatf("unexp_evt_d%0d_ch%0d", d, c), n, 1);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("evt_ch_d%0d", d), c, e.ch);
               chk($sformatf("evt_edge_d%0d_ch%0d", d, c), cyc, e.at);
               chk($sformatf("evt_kind_d%0d_ch%0d", d, c), {r[c], f[c]}, e.rise ? 2'b10 : 2'b01);
               chk($sformatf("evt_lvl_d%0d_ch%0d", d, c), st[c], e.rise);
            end
         end
      end
   endtask

   // Event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      mon(0, rise0, fall0, stable0);
      mon(1, rise1, fall1, stable1);
   end

   task automatic wait_to(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   initial begin
      int cap;
      int dw;

      // 1. Reset with all pins high.
      in0 = 4'hF;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sync",   sync0,   4'h0);
      chk("rst_stable", stable0, 4'h0);
      chk("rst_rise",   rise0,   4'h0);
      chk("rst_fall",   fall0,   4'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel1_sync",   sync0,   4'h0);
      chk("rel1_stable", stable0, 4'h0);
      chk("rel1_rise",   rise0 | fall0, 4'h0);
      @(negedge clk);
      chk("rel2_sync", sync0, 4'hF);
      in0 = 4'h0;
      repeat (6) @(negedge clk);
      chk("idle_stable", stable0, 4'h0);
      chk("idle_sync",   sync0,   4'h0);

      // 2. Clean step on ch0.
      in0[0] = 1'b1;
      cap = cyc + 1;
      push_ev(0, 0, cap + STG - 1 + DC0, 1'b1);
      wait_to(cap);
      chk("step_sync_pre",  sync0[0], 1'b0);
      wait_to(cap + 1);
      chk("step_sync_post", sync0[0], 1'b1);
      wait_to(cap + 4);
      chk("step_stable_pre", stable0[0], 1'b0);
      wait_to(cap + 5);
      chk("step_stable_post", stable0[0], 1'b1);
      chk("step_others", stable0[3:1], 3'b000);
      wait_to(cap + 6);
      chk("step_rise_gone", rise0[0], 1'b0);
      wait_to(cap + 10);
      in0[0] = 1'b0;
      cap = cyc + 1;
      push_ev(0, 0, cap + STG - 1 + DC0, 1'b0);
      wait_to(cap + 8);
      chk("step_fall_stable", stable0[0], 1'b0);

      // 3. Two-capture glitch on ch1.
      in0[1] = 1'b1;
      cap = cyc + 1;
      repeat (2) @(negedge clk);
      in0[1] = 1'b0;
      wait_to(cap + 1);
      chk("glitch_sync_a", sync0[1], 1'b1);
      wait_to(cap + 2);
      chk("glitch_sync_b", sync0[1], 1'b1);
      wait_to(cap + 3);
      chk("glitch_sync_c", sync0[1], 1'b0);
      wait_to(cap + 10);
      chk("glitch_stable", stable0[1], 1'b0);

      // 4. Chatter on ch2 (8/12 ns dwells off the clock edge), then holds.
      @(negedge clk);
      #3;
      for (int k = 0; k < 12; k++) begin
         in0[2] = ~in0[2];
         dw = (k % 2 == 0) ? 8 : 12;
         #(dw);
      end
      chk("chat_stable_mid", stable0[2], 1'b0);
      in0[2] = 1'b1;
      cap = cyc + 1;
      push_ev(0, 2, cap + STG - 1 + DC0, 1'b1);
      #80;
      chk("chat_stable_hi", stable0[2], 1'b1);
      in0[2] = 1'b0;
      cap = cyc + 1;
      push_ev(0, 2, cap + STG - 1 + DC0, 1'b0);
      #80;
      @(negedge clk);
      chk("chat_stable_lo", stable0[2], 1'b0);

      // 5. Reset while ch3 counter sits at 2.
      in0[3] = 1'b1;
      cap = cyc + 1;
      wait_to(cap + 3);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_stable", stable0[3], 1'b0);
      chk("midrst_sync",   sync0[3],   1'b0);
      rst = 1'b0;
      cap = cyc + 1;
      push_ev(0, 3, cap + STG - 1 + DC0, 1'b1);
      wait_to(cap + 4);
      chk("midrst_stable_pre", stable0[3], 1'b0);
      wait_to(cap + 5);
      chk("midrst_stable_post", stable0[3], 1'b1);
      wait_to(cap + 8);
      in0[3] = 1'b0;
      cap = cyc + 1;
      push_ev(0, 3, cap + STG - 1 + DC0, 1'b0);
      wait_to(cap + 8);

      // 6. Simultaneous ch0+ch3 steps on both builds.
      in0 = 4'b1001;
      in1 = 4'b1001;
      cap = cyc + 1;
      push_ev(0, 0, cap + STG - 1 + DC0, 1'b1);
      push_ev(0, 3, cap + STG - 1 + DC0, 1'b1);
      push_ev(1, 0, cap + STG - 1 + DC1, 1'b1);
      push_ev(1, 3, cap + STG - 1 + DC1, 1'b1);
      wait_to(cap + 1);
      chk("dc1_sync",       sync1,   4'b1001);
      chk("dc1_stable_pre", stable1, 4'b0000);
      wait_to(cap + 2);
      chk("dc1_stable_post", stable1, 4'b1001);
      wait_to(cap + 5);
      chk("multi_stable", stable0, 4'b1001);
      wait_to(cap + 8);
      in0 = 4'b0000;
      in1 = 4'b0000;
      cap = cyc + 1;
      push_ev(0, 0, cap + STG - 1 + DC0, 1'b0);
      push_ev(0, 3, cap + STG - 1 + DC0, 1'b0);
      push_ev(1, 0, cap + STG - 1 + DC1, 1'b0);
      push_ev(1, 3, cap + STG - 1 + DC1, 1'b0);
      wait_to(cap + 2);
      chk("dc1_stable_fall", stable1, 4'b0000);
      wait_to(cap + 12);

      chk("pending_q0", q0.size(), 0);
      chk("pending_q1", q1.size(), 0);
      chk("final_stable0", stable0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
